crc_process: RTL and testbench

//  Store-and-forward CRC filter behind the 10G MAC RX path. Buffers each received AXI-stream

---
 rtl/crc_process_pkg.sv | 22 ++
 rtl/crc_process_if.sv | 14 +
 rtl/crc_frame_fifo.sv | 40 ++++
 rtl/crc_process.sv | 157 +++++++++++++++
 tb/tb_crc_process.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_process_pkg.sv
// Shared AXI-stream widths, FIFO entry layout and write-side state encoding for crc_process.
package crc_process_pkg;

    localparam int unsigned AXIS_DATA_W  = 64;
    localparam int unsigned AXIS_USER_W  = 80;
    localparam int unsigned AXIS_KEEP_W  = 8;
    localparam int unsigned FIFO_ENTRY_W = AXIS_DATA_W + AXIS_USER_W + AXIS_KEEP_W + 1;

    // One buffered beat, stored exactly as received.
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_USER_W-1:0] user;
        logic [AXIS_KEEP_W-1:0] keep;
        logic                   last;
    } axis_entry_t;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0] ST_RECV     = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT_CRC = 2'd2;

endpackage

// File: rtl/crc_process_if.sv
// AXI-stream RX bundle (no ready) shared by the input and filtered output of crc_process.
interface crc_process_if;
    import crc_process_pkg::*;

    logic [AXIS_DATA_W-1:0] rdata;
    logic [AXIS_USER_W-1:0] ruser;
    logic [AXIS_KEEP_W-1:0] rkeep;
    logic                   rlast;
    logic                   rvalid;

    modport master (output rdata, ruser, rkeep, rlast, rvalid);
    modport slave  (input  rdata, ruser, rkeep, rlast, rvalid);

endinterface

// File: rtl/crc_frame_fifo.sv
// Simple dual-port frame buffer: one write port, one read port with a registered output
// that returns zero on cycles without a read, so it can drive the output stream directly.
module crc_frame_fifo
    import crc_process_pkg::*;
#(
    parameter  int unsigned P_FIFO_DEPTH = 256,
    localparam int unsigned AW           = $clog2(P_FIFO_DEPTH)
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  axis_entry_t wr_data_i,
    input  logic        rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output axis_entry_t rd_data_o
);

    axis_entry_t mem_q [P_FIFO_DEPTH];
    axis_entry_t rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/crc_process.sv
// Store-and-forward CRC filter: buffers each RX frame, commits or erases it on the late CRC
// verdict and replays committed frames. Optional counters under CRC_PROCESS_STATS_EN.
module crc_process
    import crc_process_pkg::*;
#(
    parameter int unsigned P_FIFO_DEPTH = 256
)(
    input  logic              i_clk,
    input  logic              i_rst,
    crc_process_if.slave      s_axis,
    crc_process_if.master     m_axis,
    input  logic              i_crc_error,
    input  logic              i_crc_valid
`ifdef CRC_PROCESS_STATS_EN
    ,
    output logic [31:0]       o_good_frames,
    output logic [31:0]       o_bad_frames
`endif
);

    localparam int unsigned AW = $clog2(P_FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [ST_W-1:0] state_q,  state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_q, commit_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            drop_q,   drop_d;
    logic            ovf_q,    ovf_d;
    logic            out_valid_q;

    logic            full_c;
    logic            accept_c;
    logic            wr_en_c;
    logic            verdict_c;
    logic            frame_bad_c;
    logic            pop_c;
    axis_entry_t     wr_entry_c;
    axis_entry_t     rd_entry;

    assign full_c = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign wr_entry_c = '{data: s_axis.rdata, user: s_axis.ruser,
                          keep: s_axis.rkeep, last: s_axis.rlast};

    // Write side: frame capture, discard of early frames, overflow flag and verdict handling.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        commit_d    = commit_q;
        drop_d      = drop_q;
        ovf_d       = ovf_q;
        accept_c    = 1'b0;
        wr_en_c     = 1'b0;
        verdict_c   = 1'b0;
        frame_bad_c = 1'b0;

        if (s_axis.rvalid && (drop_q || (state_q == ST_WAIT_CRC))) begin
            drop_d = !s_axis.rlast;
        end else if (s_axis.rvalid) begin
            accept_c = 1'b1;
        end

        if (accept_c) begin
            if (full_c) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_c  = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end

        case (state_q)
            ST_IDLE:     if (accept_c) state_d = s_axis.rlast ? ST_WAIT_CRC : ST_RECV;
            ST_RECV:     if (accept_c && s_axis.rlast) state_d = ST_WAIT_CRC;
            ST_WAIT_CRC: if (i_crc_valid) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // A verdict landing with the rlast beat covers that beat as well.
        verdict_c = i_crc_valid &&
                    ((state_q == ST_WAIT_CRC) || (accept_c && s_axis.rlast));
        if (verdict_c) begin
            frame_bad_c = i_crc_error || ovf_d;
            state_d     = ST_IDLE;
            ovf_d       = 1'b0;
            if (frame_bad_c) begin
                wr_ptr_d = commit_q;
            end else begin
                commit_d = wr_ptr_d;
            end
        end
    end

    assign pop_c    = (rd_ptr_q != commit_q);
    assign rd_ptr_d = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            commit_q    <= '0;
            rd_ptr_q    <= '0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            commit_q    <= commit_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            out_valid_q <= pop_c;
        end
    end

    crc_frame_fifo #(
        .P_FIFO_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_entry_c),
        .rd_en_i   (pop_c),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_entry)
    );

    // The FIFO read register is zero when idle, so the payload is already gated.
    assign m_axis.rdata  = rd_entry.data;
    assign m_axis.ruser  = rd_entry.user;
    assign m_axis.rkeep  = rd_entry.keep;
    assign m_axis.rlast  = rd_entry.last;
    assign m_axis.rvalid = out_valid_q;

`ifdef CRC_PROCESS_STATS_EN
    logic [31:0] good_q;
    logic [31:0] bad_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (verdict_c) begin
            if (!frame_bad_c && (good_q != 32'hFFFF_FFFF)) good_q <= good_q + 32'd1;
            if (frame_bad_c  && (bad_q  != 32'hFFFF_FFFF)) bad_q  <= bad_q  + 32'd1;
        end
    end

    assign o_good_frames = good_q;
    assign o_bad_frames  = bad_q;
`endif

endmodule

// File: tb/tb_crc_process.sv
// Self-checking bench for crc_process: directed and random frames against a frame-level model.
module tb_crc_process;
    import crc_process_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic [79:0] u;
        logic [7:0]  k;
        logic        l;
        bit          first;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic crc_v0, crc_e0, crc_v8, crc_e8;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   idle_nz = 0;
    int   tgt = 0;
    int   vcyc = 0;
    int   good_m [2];
    int   bad_m  [2];
    beat_t exp0[$], got0[$], exp8[$], got8[$], pend[$];

    crc_process_if s0(), m0(), s8(), m8();

`ifdef CRC_PROCESS_STATS_EN
    logic [31:0] good0, bad0, good8, bad8;
`endif

    crc_process #(.P_FIFO_DEPTH(256)) dut (
        .i_clk(clk), .i_rst(rst), .s_axis(s0), .m_axis(m0),
        .i_crc_error(crc_e0), .i_crc_valid(crc_v0)
`ifdef CRC_PROCESS_STATS_EN
        , .o_good_frames(good0), .o_bad_frames(bad0)
`endif
    );

    crc_process #(.P_FIFO_DEPTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .s_axis(s8), .m_axis(m8),
        .i_crc_error(crc_e8), .i_crc_valid(crc_v8)
`ifdef CRC_PROCESS_STATS_EN
        , .o_good_frames(good8), .o_bad_frames(bad8)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records emitted beats with their cycle, counts non-zero idle payloads.
    always @(negedge clk) begin
        beat_t b;
        if (m0.rvalid === 1'b1) begin
            b.d = m0.rdata; b.u = m0.ruser; b.k = m0.rkeep; b.l = m0.rlast;
            b.first = 1'b0; b.cyc = cyc;
            got0.push_back(b);
        end else if ({m0.rdata, m0.ruser, m0.rkeep, m0.rlast} !== '0) idle_nz++;
        if (m8.rvalid === 1'b1) begin
            b.d = m8.rdata; b.u = m8.ruser; b.k = m8.rkeep; b.l = m8.rlast;
            b.first = 1'b0; b.cyc = cyc;
            got8.push_back(b);
        end else if ({m8.rdata, m8.ruser, m8.rkeep, m8.rlast} !== '0) idle_nz++;
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [79:0] u,
                         input logic [7:0] k, input logic l, input logic cv, input logic ce);
        @(posedge clk); #1;
        if (tgt == 0) begin
            s0.rvalid = v; s0.rdata = d; s0.ruser = u; s0.rkeep = k; s0.rlast = l;
            crc_v0 = cv; crc_e0 = ce;
        end else begin
            s8.rvalid = v; s8.rdata = d; s8.ruser = u; s8.rkeep = k; s8.rlast = l;
            crc_v8 = cv; crc_e8 = ce;
        end
        if (cv) vcyc = cyc;
    endtask

    task automatic idle(input logic cv = 1'b0, input logic ce = 1'b0);
        drive(1'b0, 64'd0, 80'd0, 8'd0, 1'b0, cv, ce);
    endtask

    function automatic logic [79:0] rnd_user();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Frame-level model: a pending frame becomes visible only if good and within FIFO depth.
    task automatic resolve(input bit err);
        int depth = (tgt == 0) ? 256 : 8;
        if (!err && pend.size() <= depth) begin
            foreach (pend[i]) begin
                if (tgt == 0) exp0.push_back(pend[i]); else exp8.push_back(pend[i]);
            end
            good_m[tgt]++;
        end else begin
            bad_m[tgt]++;
        end
        pend.delete();
    endtask

    task automatic send_beats(input int nb, input logic [7:0] lkeep, input logic [79:0] user,
                              input bit keep_it, input bit same_v, input bit err);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.d = {$urandom, $urandom}; b.u = user;
            b.l = (i == nb - 1); b.k = b.l ? lkeep : 8'hFF;
            b.first = (i == 0); b.cyc = 0;
            drive(1'b1, b.d, b.u, b.k, b.l, same_v && b.l, err);
            if (keep_it) pend.push_back(b);
        end
        if (same_v) resolve(err);
    endtask

    task automatic verdict(input bit err);
        idle(1'b1, err);
        resolve(err);
    endtask

    task automatic check_stream(input string tag, input int first_cyc);
        beat_t e[$], g[$];
        int n;
        repeat (40) idle();
        if (tgt == 0) begin e = exp0; g = got0; exp0.delete(); got0.delete(); end
        else          begin e = exp8; g = got8; exp8.delete(); got8.delete(); end
        chk({tag, "_count"}, 160'(g.size()), 160'(e.size()));
        n = (g.size() < e.size()) ? g.size() : e.size();
        if (first_cyc >= 0 && n > 0) chk({tag, "_latency"}, 160'(g[0].cyc), 160'(first_cyc));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_beat%0d", tag, i), {g[i].d, g[i].u, g[i].k, g[i].l},
                {e[i].d, e[i].u, e[i].k, e[i].l});
            if (i > 0 && !e[i].first)
                chk($sformatf("%s_contig%0d", tag, i), 160'(g[i].cyc), 160'(g[i-1].cyc + 1));
        end
    endtask

    initial begin
        logic [79:0] user1;
        logic [7:0]  keeps [6];
        bit          errs  [6];
        bit          err, same;
        int          nb, gap;

        keeps = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hFC, 8'hFF};
        errs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        user1 = {16'd10, 48'd0, 16'h0800};
        good_m = '{0, 0}; bad_m = '{0, 0};
        tgt = 1; idle();
        tgt = 0; idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_m0", {m0.rdata, m0.ruser, m0.rkeep, m0.rlast, m0.rvalid}, 160'd0);
        chk("reset_m8", {m8.rdata, m8.ruser, m8.rkeep, m8.rlast, m8.rvalid}, 160'd0);
        rst = 1'b0;

        // Good frame, verdict 3 cycles after rlast.
        send_beats(5, 8'hF0, user1, 1, 0, 0);
        repeat (2) idle();
        verdict(0);
        check_stream("t1", vcyc + 2);

        // Bad frame erased; next good frame reuses the space.
        send_beats(5, 8'hF0, user1, 1, 0, 0);
        repeat (2) idle();
        verdict(1);
        send_beats(5, 8'hF0, user1, 1, 0, 0);
        verdict(0);
        check_stream("t2", vcyc + 2);

        // Mixed verdict sequence.
        for (int f = 0; f < 6; f++) begin
            send_beats($urandom_range(2, 6), keeps[f], rnd_user(), 1, 0, 0);
            repeat ($urandom_range(0, 2)) idle();
            verdict(errs[f]);
        end
        check_stream("t3", -1);

        // Verdict with rlast, then stray verdicts while idle.
        send_beats(4, 8'hFE, rnd_user(), 1, 1, 0);
        check_stream("t4a", vcyc + 2);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        send_beats(3, 8'hE0, rnd_user(), 1, 0, 0);
        idle();
        verdict(0);
        check_stream("t4b", vcyc + 2);

        // Second frame before first verdict: dropped whole.
        send_beats(3, 8'hC0, rnd_user(), 1, 0, 0);
        idle();
        send_beats(4, 8'hF0, rnd_user(), 0, 0, 0);
        verdict(0);
        check_stream("t5a", vcyc + 2);
        send_beats(3, 8'hC0, rnd_user(), 1, 0, 0);
        drive(1'b1, 64'h1, 80'h1, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h2, 80'h2, 8'hFF, 1'b0, 1'b1, 1'b1);
        resolve(1);
        drive(1'b1, 64'h3, 80'h3, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h4, 80'h4, 8'hF8, 1'b1, 1'b0, 1'b0);
        send_beats(2, 8'h80, rnd_user(), 1, 0, 0);
        verdict(0);
        check_stream("t5b", vcyc + 2);
        send_beats(2, 8'hFC, rnd_user(), 1, 0, 0);
        drive(1'b1, 64'h5, 80'h5, 8'hFF, 1'b0, 1'b1, 1'b0);
        resolve(0);
        drive(1'b1, 64'h6, 80'h6, 8'hF0, 1'b1, 1'b0, 1'b0);
        check_stream("t5c", vcyc + 2);

        // Reset in the middle of a frame.
        send_beats(3, 8'hFF, rnd_user(), 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_m0", {m0.rdata, m0.ruser, m0.rkeep, m0.rlast, m0.rvalid}, 160'd0);
        good_m = '{0, 0}; bad_m = '{0, 0};
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        send_beats(4, 8'hF0, rnd_user(), 1, 0, 0);
        verdict(0);
        check_stream("t_rst", vcyc + 2);

        // Random frames and verdict timing.
        for (int f = 0; f < 25; f++) begin
            nb   = $urandom_range(1, 12);
            err  = ($urandom_range(0, 3) == 0);
            same = (nb > 1) && ($urandom_range(0, 1) == 1);
            gap  = $urandom_range(0, 3);
            send_beats(nb, 8'(8'hFF << $urandom_range(0, 7)), rnd_user(), 1, same, err);
            if (!same) begin
                repeat (gap) idle();
                verdict(err);
            end
        end
        check_stream("rand", -1);

        // Overflow on the 8-deep instance, then boundary fill and recovery.
        tgt = 1;
        send_beats(10, 8'hF0, rnd_user(), 1, 0, 0);
        verdict(0);
        check_stream("t6_ovf", -1);
        send_beats(8, 8'hC0, rnd_user(), 1, 0, 0);
        verdict(0);
        check_stream("t6_full", vcyc + 2);
        send_beats(5, 8'hF0, rnd_user(), 1, 0, 0);
        verdict(0);
        check_stream("t6_after", vcyc + 2);
        idle();
        tgt = 0;

`ifdef CRC_PROCESS_STATS_EN
        chk("good0", 160'(good0), 160'(good_m[0]));
        chk("bad0",  160'(bad0),  160'(bad_m[0]));
        chk("good8", 160'(good8), 160'(good_m[1]));
        chk("bad8",  160'(bad8),  160'(bad_m[1]));
`endif
        chk("idle_payload_zero", 160'(idle_nz), 160'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
